// File: rtl/pipe_issue_arbiter_pkg.sv
// Shared definitions for the pipe-slot issue arbiter: FSM state encoding,
// slot-count ceiling and the round-robin one-hot picker used by the hazard unit too.
package pipe_issue_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int NSLOT_MAX   = 8;
    localparam int NSLOT_MAX_W = 3;

    // First set request at or after ptr, wrapping modulo n; returns one-hot or zero.
    function automatic logic [NSLOT_MAX-1:0] rr_pick(
        input logic [NSLOT_MAX-1:0] req,
        input int unsigned          ptr,
        input int unsigned          n
    );
        logic [NSLOT_MAX-1:0] grant;
        int unsigned          idx;
        grant = '0;
        for (int unsigned k = 0; k < NSLOT_MAX; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if ((grant == '0) && req[idx[NSLOT_MAX_W-1:0]])
                    grant[idx[NSLOT_MAX_W-1:0]] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/pipe_issue_arbiter_if.sv
// Fetch/write-back handshake between the pipe FSM slots (master) and the
// issue arbiter (slave).
interface pipe_issue_arbiter_if #(
    parameter int NSLOT  = 3,
    parameter int SLOT_W = 2
);
    logic              imem_valid;
    logic              stall;
    logic [NSLOT-1:0]  fetch_req;
    logic [NSLOT-1:0]  wb_done;
    logic              flush;
    logic [SLOT_W-1:0] flush_id;
    logic [NSLOT-1:0]  ack;
    logic [NSLOT-1:0]  wb_ack;
    logic [SLOT_W-1:0] issue_id;

    modport master (
        output imem_valid, stall, fetch_req, wb_done, flush, flush_id,
        input  ack, wb_ack, issue_id
    );

    modport slave (
        input  imem_valid, stall, fetch_req, wb_done, flush, flush_id,
        output ack, wb_ack, issue_id
    );
endinterface

// File: rtl/pipe_issue_arbiter_slot_order_fifo.sv
// In-order retire queue of slot ids: push at tail, pop at head, and truncate
// everything younger than a given id when that id is present.
module pipe_issue_arbiter_slot_order_fifo
    import pipe_issue_arbiter_pkg::*;
#(
    parameter int NSLOT  = 3,
    parameter int SLOT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [SLOT_W-1:0] i_push_id,
    input  logic              i_pop,
    input  logic              i_trunc,
    input  logic [SLOT_W-1:0] i_trunc_id,
    output logic [SLOT_W-1:0] o_head_id,
    output logic [SLOT_W:0]   o_count,
    output logic [NSLOT-1:0]  o_queued
);

    localparam logic [SLOT_W:0] NS = (SLOT_W+1)'(NSLOT);

    logic [SLOT_W-1:0] r_mem [NSLOT];
    logic [SLOT_W-1:0] r_head, r_tail;
    logic [SLOT_W:0]   r_count;

    logic [SLOT_W-1:0] w_head_nxt, w_tail_nxt, w_hit_off;
    logic [SLOT_W:0]   w_count_nxt;
    logic              w_hit, w_do_push, w_do_pop;

    function automatic logic [SLOT_W-1:0] wrap(input logic [SLOT_W:0] v);
        return (v >= NS) ? SLOT_W'(v - NS) : SLOT_W'(v);
    endfunction

    // Walk the live entries oldest-first: occupancy map and truncation point.
    always_comb begin
        logic [SLOT_W-1:0] pos;
        pos       = '0;
        w_hit     = 1'b0;
        w_hit_off = '0;
        o_queued  = '0;
        for (int i = 0; i < NSLOT; i++) begin
            pos = wrap({1'b0, r_head} + (SLOT_W+1)'(i));
            if ((SLOT_W+1)'(i) < r_count) begin
                for (int j = 0; j < NSLOT; j++)
                    if (r_mem[pos] == SLOT_W'(j)) o_queued[j] = 1'b1;
                if (!w_hit && (r_mem[pos] == i_trunc_id)) begin
                    w_hit     = 1'b1;
                    w_hit_off = SLOT_W'(i);
                end
            end
        end
    end

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (r_count != NS) && !(i_trunc && w_hit);

    // The kept entry fixes the new tail; a same-cycle pop only moves the head.
    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (w_do_pop) w_head_nxt = wrap({1'b0, r_head} + (SLOT_W+1)'(1));
        if (i_trunc && w_hit) begin
            w_tail_nxt  = wrap({1'b0, r_head} + {1'b0, w_hit_off} + (SLOT_W+1)'(1));
            w_count_nxt = {1'b0, w_hit_off} + (SLOT_W+1)'(1) - (SLOT_W+1)'(w_do_pop);
        end else begin
            if (w_do_push) w_tail_nxt = wrap({1'b0, r_tail} + (SLOT_W+1)'(1));
            w_count_nxt = r_count + (SLOT_W+1)'(w_do_push) - (SLOT_W+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_tail] <= i_push_id;
    end

    assign o_head_id = r_mem[r_head];
    assign o_count   = r_count;

endmodule

// File: rtl/pipe_issue_arbiter.sv
// Issue arbiter for the pipe FSM slots: round-robin fetch grant, in-order retire
// permission, flush truncation and drain-to-idle. PIPE_ISSUE_STATS_EN adds counters.
module pipe_issue_arbiter
    import pipe_issue_arbiter_pkg::*;
#(
    parameter int NSLOT  = 3,
    parameter int SLOT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_halt,
    pipe_issue_arbiter_if.slave  bus,
    output logic [SLOT_W:0]      o_q_count,
    output logic                 o_busy
`ifdef PIPE_ISSUE_STATS_EN
    ,
    output logic [31:0]          o_stat_issued,
    output logic [31:0]          o_stat_retired,
    output logic [31:0]          o_stat_stall
`endif
);

    localparam logic [SLOT_W:0] NS = (SLOT_W+1)'(NSLOT);

    state_e            r_state, w_state_nxt;
    logic [SLOT_W-1:0] r_rr_ptr;
    logic              w_run, w_grant_ok, w_pop;
    logic [NSLOT-1:0]  w_req_eff, w_queued, w_ack, w_wb_ack;
    logic [SLOT_W-1:0] w_issue_id, w_head_id;
    logic [SLOT_W:0]   w_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start)          w_state_nxt = ST_RUN;
            ST_RUN:   if (i_halt)           w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_count == '0)    w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_run  = (r_state == ST_RUN);
        o_busy = (r_state != ST_IDLE);
    end

    // Slots already waiting in the retire queue cannot be granted again.
    assign w_req_eff  = bus.fetch_req & ~w_queued;
    assign w_grant_ok = w_run && bus.imem_valid && !bus.stall && !bus.flush && (w_count != NS);

    always_comb begin
        w_ack = '0;
        if (w_grant_ok)
            w_ack = NSLOT'(rr_pick(NSLOT_MAX'(w_req_eff), 32'(r_rr_ptr), 32'(NSLOT)));
    end

    always_comb begin
        w_issue_id = '0;
        for (int i = 0; i < NSLOT; i++)
            if (w_ack[i]) w_issue_id = SLOT_W'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rr_ptr <= '0;
        else if (|w_ack)
            r_rr_ptr <= (w_issue_id == SLOT_W'(NSLOT - 1)) ? '0 : w_issue_id + 1'b1;
    end

    always_comb begin
        w_wb_ack = '0;
        for (int i = 0; i < NSLOT; i++)
            w_wb_ack[i] = (w_count != '0) && (w_head_id == SLOT_W'(i));
    end

    assign w_pop = |(bus.wb_done & w_wb_ack);

    pipe_issue_arbiter_slot_order_fifo #(
        .NSLOT  (NSLOT),
        .SLOT_W (SLOT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (|w_ack),
        .i_push_id  (w_issue_id),
        .i_pop      (w_pop),
        .i_trunc    (bus.flush),
        .i_trunc_id (bus.flush_id),
        .o_head_id  (w_head_id),
        .o_count    (w_count),
        .o_queued   (w_queued)
    );

    assign bus.ack      = w_ack;
    assign bus.wb_ack   = w_wb_ack;
    assign bus.issue_id = w_issue_id;
    assign o_q_count    = w_count;

`ifdef PIPE_ISSUE_STATS_EN
    logic [31:0] r_stat_issued, r_stat_retired, r_stat_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_issued  <= '0;
            r_stat_retired <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (|w_ack)                          r_stat_issued  <= r_stat_issued + 32'd1;
            if (w_pop)                           r_stat_retired <= r_stat_retired + 32'd1;
            if (w_run && |bus.fetch_req && ~|w_ack) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign o_stat_issued  = r_stat_issued;
    assign o_stat_retired = r_stat_retired;
    assign o_stat_stall   = r_stat_stall;
`endif

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Scoreboard bench for pipe_issue_arbiter: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_pipe_issue_arbiter;

    localparam int N = 3;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, halt;
    logic [W:0]   q_count;
    logic         busy;
`ifdef PIPE_ISSUE_STATS_EN
    logic [31:0]  st_iss, st_ret, st_stl;
`endif

    pipe_issue_arbiter_if #(.NSLOT(N), .SLOT_W(W)) bus ();

    pipe_issue_arbiter #(.NSLOT(N), .SLOT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (start),
        .i_halt    (halt),
        .bus       (bus.slave),
        .o_q_count (q_count),
        .o_busy    (busy)
`ifdef PIPE_ISSUE_STATS_EN
        ,
        .o_stat_issued  (st_iss),
        .o_stat_retired (st_ret),
        .o_stat_stall   (st_stl)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned ack;
        int unsigned wb_ack;
        int unsigned issue_id;
        int unsigned q_count;
        int unsigned busy;
        int unsigned iss;
        int unsigned ret;
        int unsigned stl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: state 0=idle 1=run 2=drain, retire order as a plain queue.
    int          m_st;
    int          m_q[$];
    int          m_rr;
    int unsigned m_iss, m_ret, m_stl;

    task automatic model_reset();
        m_st = 0; m_q.delete(); m_rr = 0;
        m_iss = 0; m_ret = 0; m_stl = 0;
    endtask

    function automatic bit in_q(input int s);
        foreach (m_q[i]) if (m_q[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit h, input bit iv, input bit stl,
                       input int req, input int done, input bit fl, input int fid);
        exp_t e;
        int   g, nst, p, sl;
        bit   pop;
        @(posedge clk); #1;
        rst = r; start = s; halt = h;
        bus.imem_valid = iv; bus.stall = stl;
        bus.fetch_req = req[N-1:0]; bus.wb_done = done[N-1:0];
        bus.flush = fl; bus.flush_id = fid[W-1:0];
        if (r) model_reset();
        g = -1;
        if (!r && m_st == 1 && iv && !stl && !fl && m_q.size() < N) begin
            for (int k = 0; k < N; k++) begin
                sl = (m_rr + k) % N;
                if (g < 0 && req[sl] && !in_q(sl)) g = sl;
            end
        end
        e.ack      = (g >= 0) ? (1 << g) : 0;
        e.issue_id = (g >= 0) ? g : 0;
        e.wb_ack   = (m_q.size() > 0) ? (1 << m_q[0]) : 0;
        e.q_count  = m_q.size();
        e.busy     = (m_st != 0);
        e.iss = m_iss; e.ret = m_ret; e.stl = m_stl;
        exp_q.push_back(e);
        if (!r) begin
            pop = (m_q.size() > 0) && done[m_q[0]];
            nst = m_st;
            if (m_st == 0 && s) nst = 1;
            else if (m_st == 1 && h) nst = 2;
            else if (m_st == 2 && m_q.size() == 0) nst = 0;
            if (g >= 0) m_iss++;
            if (pop) m_ret++;
            if (m_st == 1 && req[N-1:0] != 0 && g < 0) m_stl++;
            p = -1;
            foreach (m_q[i]) if (m_q[i] == fid) p = i;
            if (fl && p >= 0) while (m_q.size() > p + 1) void'(m_q.pop_back());
            if (pop) void'(m_q.pop_front());
            if (g >= 0) begin
                m_q.push_back(g);
                m_rr = (g + 1) % N;
            end
            m_st = nst;
        end
    endtask

    // Monitor: compares every presented output cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ack",      bus.ack,      e.ack);
                chk("wb_ack",   bus.wb_ack,   e.wb_ack);
                chk("issue_id", bus.issue_id, e.issue_id);
                chk("q_count",  q_count,      e.q_count);
                chk("busy",     busy,         e.busy);
`ifdef PIPE_ISSUE_STATS_EN
                chk("stat_issued",  st_iss, e.iss);
                chk("stat_retired", st_ret, e.ret);
                chk("stat_stall",   st_stl, e.stl);
`endif
            end
        end
    end

    initial begin
        int req, done, fid;
        bit r, s, h, iv, stl, fl;
        rst = 1'b1; start = 1'b0; halt = 1'b0;
        bus.imem_valid = 1'b0; bus.stall = 1'b0; bus.fetch_req = '0;
        bus.wb_done = '0; bus.flush = 1'b0; bus.flush_id = '0;
        model_reset();

        //   r s h iv st req done fl fid
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // fill to full with all slots requesting
        cyc(0, 1, 0, 1, 0, 7, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 1, 0, 7, 0, 0, 0);
        // non-head write-back ignored, then in-order retire
        cyc(0, 0, 0, 1, 0, 0, 2, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 2, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 4, 0, 0);
        // refill, flush keeping slot 0, then append after it
        repeat (3) cyc(0, 0, 0, 1, 0, 7, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 7, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 7, 0, 0, 0);
        // pop of the flushing head empties the queue
        cyc(0, 0, 0, 1, 0, 0, 1, 1, 0);
        // stall and missing instruction suppress grants
        cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 1, 0, 3, 0, 0, 0);
        // halt, drain two entries, fall back to idle
        cyc(0, 0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 7, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 2, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        // reset in the middle of a run
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 1, 0, 7, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 7, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            s   = ($urandom_range(0, 7) == 0);
            h   = ($urandom_range(0, 39) == 0);
            iv  = ($urandom_range(0, 4) != 0);
            stl = ($urandom_range(0, 5) == 0);
            req = $urandom_range(0, 7);
            if ($urandom_range(0, 2) == 0) done = $urandom_range(0, 7);
            else if (m_q.size() > 0 && $urandom_range(0, 1) == 1) done = 1 << m_q[0];
            else done = 0;
            fl  = ($urandom_range(0, 11) == 0);
            fid = $urandom_range(0, 3);
            cyc(r, s, h, iv, stl, req, done, fl, fid);
        end

        @(negedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
